tiny_riscv_mem_arbiter: RTL

Shares the single synchronous-read firmware memory between two requesters: instruction fetch (port I) and data load (port D). Each request is registered and issued to the memory as one read strobe, the one-cycle memory read latency is absorbed, and the result is returned to the originating requester. Ties are broken round-robin, and out-of-range addresses are rejected without touching memory. It sits between the core's fetch/load-store units and the memory block.

---
 rtl/tiny_riscv_mem_pkg.sv | 17 +
 rtl/tiny_riscv_rr_arb2.sv | 31 +++
 rtl/tiny_riscv_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tiny_riscv_mem_pkg.sv
// rtl/tiny_riscv_mem_pkg.sv - shared types and constants for the firmware memory arbiter
package tiny_riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Requester IDs double as bit positions in the arbiter's request/grant vectors.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned MEM_WORDS_DEFAULT = 256;

endpackage

// File: rtl/tiny_riscv_rr_arb2.sv
// rtl/tiny_riscv_rr_arb2.sv - two-input round-robin / fixed-priority arbiter (combinational)
//
// Ports:
//   req_i       [1:0] request vector, bit REQ_I = fetch, bit REQ_D = load
//   last_i            ID of the requester granted most recently
//   enable_rr_i       1 = round-robin on a tie, 0 = D always wins a tie
//   grant_o     [1:0] one-hot grant, all zero when nothing requests
module tiny_riscv_rr_arb2
    import tiny_riscv_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       enable_rr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                // On a tie, round-robin favours whoever was not served last.
                if (enable_rr_i && (last_i == REQ_D)) grant_o = 2'b01;
                else                                  grant_o = 2'b10;
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/tiny_riscv_mem_arbiter.sv
// rtl/tiny_riscv_mem_arbiter.sv - shares one synchronous-read memory between fetch and load ports
//
// Ports:
//   i_Clk, i_Rst                      clock, asynchronous active-high reset
//   i_ifetch_req/addr                 fetch request (held until o_ifetch_valid) and byte address
//   o_ifetch_valid/rdata/err          one-cycle fetch response, data, out-of-range flag
//   i_data_req/addr                   load request and byte address
//   o_data_valid/rdata/err            one-cycle load response, data, out-of-range flag
//   o_mem_addr, o_read_strobe         registered address and read strobe to the memory
//   i_mem_data                        memory read data, valid the cycle after the strobe
//   o_busy                            high whenever a transaction is in progress
module tiny_riscv_mem_arbiter
    import tiny_riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter bit          RR_ENABLE = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_ifetch_req,
    input  logic [31:0] i_ifetch_addr,
    output logic        o_ifetch_valid,
    output logic [31:0] o_ifetch_rdata,
    output logic        o_ifetch_err,
    input  logic        i_data_req,
    input  logic [31:0] i_data_addr,
    output logic        o_data_valid,
    output logic [31:0] o_data_rdata,
    output logic        o_data_err,
    output logic [31:0] o_mem_addr,
    output logic        o_read_strobe,
    input  logic [31:0] i_mem_data,
    output logic        o_busy
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    arb_state_t  state_q, state_d;
    logic        last_q, last_d;
    logic        grant_q, grant_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        strobe_q, strobe_d;
    logic        i_valid_q, i_valid_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_err_q, i_err_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    logic [1:0]  req_vec;
    logic [1:0]  gnt_vec;
    logic        win_id;
    logic [31:0] win_addr;
    logic        win_in_range;

    always_comb begin
        req_vec        = 2'b00;
        req_vec[REQ_I] = i_ifetch_req;
        req_vec[REQ_D] = i_data_req;
    end

    tiny_riscv_rr_arb2 u_arb (
        .req_i       (req_vec),
        .last_i      (last_q),
        .enable_rr_i (RR_ENABLE),
        .grant_o     (gnt_vec)
    );

    assign win_id       = gnt_vec[REQ_D];
    assign win_addr     = (win_id == REQ_D) ? i_data_addr : i_ifetch_addr;
    assign win_in_range = (win_addr < ADDR_LIMIT);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        mem_addr_d = mem_addr_q;
        strobe_d   = 1'b0;
        i_valid_d  = 1'b0;
        i_rdata_d  = i_rdata_q;
        i_err_d    = i_err_q;
        d_valid_d  = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_err_d    = d_err_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    grant_d = win_id;
                    last_d  = win_id;
                    if (win_in_range) begin
                        mem_addr_d = win_addr;
                        strobe_d   = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        // Out of range: answer directly, memory is never touched.
                        if (win_id == REQ_D) begin
                            d_rdata_d = 32'h0;
                            d_err_d   = 1'b1;
                            d_valid_d = 1'b1;
                        end else begin
                            i_rdata_d = 32'h0;
                            i_err_d   = 1'b1;
                            i_valid_d = 1'b1;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (grant_q == REQ_D) begin
                    d_rdata_d = i_mem_data;
                    d_err_d   = 1'b0;
                    d_valid_d = 1'b1;
                end else begin
                    i_rdata_d = i_mem_data;
                    i_err_d   = 1'b0;
                    i_valid_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            // Requests are ignored here so a req still high during its own
            // valid pulse is not served twice.
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            last_q     <= REQ_D;
            grant_q    <= REQ_I;
            mem_addr_q <= 32'h0;
            strobe_q   <= 1'b0;
            i_valid_q  <= 1'b0;
            i_rdata_q  <= 32'h0;
            i_err_q    <= 1'b0;
            d_valid_q  <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            mem_addr_q <= mem_addr_d;
            strobe_q   <= strobe_d;
            i_valid_q  <= i_valid_d;
            i_rdata_q  <= i_rdata_d;
            i_err_q    <= i_err_d;
            d_valid_q  <= d_valid_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    assign o_ifetch_valid = i_valid_q;
    assign o_ifetch_rdata = i_rdata_q;
    assign o_ifetch_err   = i_err_q;
    assign o_data_valid   = d_valid_q;
    assign o_data_rdata   = d_rdata_q;
    assign o_data_err     = d_err_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_read_strobe  = strobe_q;
    assign o_busy         = (state_q != ST_IDLE);

endmodule
